// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the instruction cache: word type, frame view and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Widest tag the cache can need, reached at the smallest legal NSETS of 2.
  localparam int TAG_MAX_W = 29;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    word_t                data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_dm_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking miss FSM,
// whole-cache flush and saturating hit/miss counters.
module icache_dm
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int CNTW  = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            imemREN,
  input  word_t           imemaddr,
  output logic            ihit,
  output word_t           imemload,
  output logic            iREN,
  output word_t           iaddr,
  input  logic            iwait,
  input  word_t           iload,
  input  logic            flush,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  typedef logic [IW-1:0] idx_t;
  typedef logic [TW-1:0] tag_t;

  logic [NSETS-1:0] valid_q, valid_d;
  tag_t             tag_q  [NSETS];
  word_t            data_q [NSETS];

  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  logic          poison_q, poison_d;

  idx_t          req_idx, miss_idx;
  tag_t          req_tag, miss_tag;
  icache_frame_t frame;
  logic          lookup_hit;
  logic          fill_we;
  logic          miss_inc;
  logic          unused_addr_bits;

  assign req_idx          = imemaddr[2 +: IW];
  assign req_tag          = imemaddr[31 -: TW];
  assign miss_idx         = miss_addr_q[2 +: IW];
  assign miss_tag         = miss_addr_q[31 -: TW];
  assign unused_addr_bits = ^imemaddr[1:0];

  always_comb begin
    frame       = '0;
    frame.valid = valid_q[req_idx];
    frame.tag   = TAG_MAX_W'(tag_q[req_idx]);
    frame.data  = data_q[req_idx];
  end

  assign lookup_hit = frame.valid && (frame.tag == TAG_MAX_W'(req_tag));

  // A started fill always runs to completion; a flush seen meanwhile only poisons it.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    poison_d    = poison_q;
    ihit        = 1'b0;
    imemload    = frame.data;
    iREN        = 1'b0;
    iaddr       = '0;
    fill_we     = 1'b0;
    miss_inc    = 1'b0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          ihit = imemREN && lookup_hit && !flush;
          if (imemREN && !lookup_hit && !flush) begin
            state_d     = FETCH;
            miss_addr_d = {imemaddr[31:2], 2'b00};
            miss_inc    = 1'b1;
          end
        end
        FETCH: begin
          iREN  = 1'b1;
          iaddr = miss_addr_q;
          if (!iwait) begin
            fill_we  = 1'b1;
            state_d  = IDLE;
            poison_d = 1'b0;
          end else if (flush) begin
            poison_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_we) begin
      valid_d[miss_idx] = !poison_q;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      poison_q    <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      poison_q    <= poison_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Tag and data carry no reset; the valid bits alone say what is resident.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= iload;
    end
  end

  sat_counter #(
    .W(CNTW)
  ) u_hit_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (flush),
    .inc  (ihit),
    .count(hit_count)
  );

  sat_counter #(
    .W(CNTW)
  ) u_miss_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (flush),
    .inc  (miss_inc),
    .count(miss_count)
  );

endmodule
